stand_dff: RTL and testbench

- Emulates a tube-style edge-triggered D flip-flop with inertial propagation delays, driven by a fast simulation tick.
- Sits directly downstream of the and-or-invert standard-cell emulator and consumes its delayed outputs as trigger, data and preset/clear.
- Together the two blocks reproduce the analog timing of the tube logic in the FPGA, so synchronisation, setup and race behaviour match real hardware.
- Also flags setup-time violations so firmware can detect marginal timing.

---
 rtl/stand_dff.sv | 128 ++++++++++++
 tb/tb_stand_dff.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/stand_dff.sv
// Tube-style edge-triggered D flip-flop with inertial output delays, stepped by the U tick.
// Also keeps a sticky flag for trigger edges that arrive before D has settled.
module stand_dff #(
  parameter int unsigned TSU  = 20,
  parameter int unsigned TPLH = 280,
  parameter int unsigned TPHL = 28,
  parameter int unsigned CW   = 9
) (
  input  logic U,
  input  logic _RESET,
  input  logic T,
  input  logic D,
  input  logic _PS,
  input  logic _PC,
  output logic Q,
  output logic _Q,
  output logic VIOL,
  input  logic VCLR
);

  localparam logic [CW-1:0] TsuC  = CW'(TSU);
  localparam logic [CW-1:0] PlhM1 = CW'(TPLH - 1);
  localparam logic [CW-1:0] PhlM1 = CW'(TPHL - 1);

  logic          s_q, s_d;
  logic          t_prev_q;
  logic          d_prev_q;
  logic [CW-1:0] dage_q, dage_d;
  logic          viol_q, viol_d;
  logic          q_q, q_d;
  logic          nq_q, nq_d;
  logic [CW-1:0] q_cnt_q, q_cnt_d;
  logic [CW-1:0] nq_cnt_q, nq_cnt_d;

  logic trise;
  logic ctrl_idle;
  logic both_low;
  logic d_changed;
  logic tq, tnq;

  always_comb begin
    trise     = T & ~t_prev_q;
    ctrl_idle = _PS & _PC;
    both_low  = ~_PS & ~_PC;
    d_changed = D ^ d_prev_q;

    s_d = s_q;
    if (!_PS && _PC) begin
      s_d = 1'b1;
    end else if (!_PC && _PS) begin
      s_d = 1'b0;
    end else if (ctrl_idle && trise) begin
      s_d = D;
    end

    // Age of D in ticks, saturating once the setup window is satisfied.
    dage_d = dage_q;
    if (d_changed) begin
      dage_d = '0;
    end else if (dage_q < TsuC) begin
      dage_d = dage_q + 1'b1;
    end

    viol_d = viol_q;
    if (trise && ctrl_idle && (d_changed || (dage_q < TsuC))) begin
      viol_d = 1'b1;
    end else if (VCLR) begin
      viol_d = 1'b0;
    end

    // Both controls low drives both tube outputs high.
    tq  = s_q | both_low;
    tnq = ~s_q | both_low;
  end

  always_comb begin
    q_d     = q_q;
    q_cnt_d = '0;
    if (tq != q_q) begin
      if (q_cnt_q == (tq ? PlhM1 : PhlM1)) begin
        q_d = tq;
      end else begin
        q_cnt_d = q_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    nq_d     = nq_q;
    nq_cnt_d = '0;
    if (tnq != nq_q) begin
      if (nq_cnt_q == (tnq ? PlhM1 : PhlM1)) begin
        nq_d = tnq;
      end else begin
        nq_cnt_d = nq_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge U) begin
    if (!_RESET) begin
      s_q      <= 1'b0;
      t_prev_q <= T;
      d_prev_q <= D;
      dage_q   <= '0;
      viol_q   <= 1'b0;
      q_q      <= 1'b0;
      nq_q     <= 1'b1;
      q_cnt_q  <= '0;
      nq_cnt_q <= '0;
    end else begin
      s_q      <= s_d;
      t_prev_q <= T;
      d_prev_q <= D;
      dage_q   <= dage_d;
      viol_q   <= viol_d;
      q_q      <= q_d;
      nq_q     <= nq_d;
      q_cnt_q  <= q_cnt_d;
      nq_cnt_q <= nq_cnt_d;
    end
  end

  assign Q    = q_q;
  assign _Q   = nq_q;
  assign VIOL = viol_q;

endmodule

// File: tb/tb_stand_dff.sv
// Bench for stand_dff: directed scenarios plus random stimulus, all checked every tick
// against a run-length based reference model.
module tb_stand_dff;

  localparam int TSU  = 20;
  localparam int TPLH = 280;
  localparam int TPHL = 28;

  logic clk;
  logic rst_n, t, d, ps_n, pc_n, vclr;
  logic q, q_n, viol;

  stand_dff #(
    .TSU (TSU),
    .TPLH(TPLH),
    .TPHL(TPHL),
    .CW  (9)
  ) dut (
    .U     (clk),
    ._RESET(rst_n),
    .T     (t),
    .D     (d),
    ._PS   (ps_n),
    ._PC   (pc_n),
    .Q     (q),
    ._Q    (q_n),
    .VIOL  (viol),
    .VCLR  (vclr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int e        = 0;

  // Reference model state
  logic m_s, m_t_prev, m_d_prev, m_viol, m_q, m_nq;
  logic m_tq_last, m_tnq_last;
  int   m_last_chg, m_tq_run, m_tnq_run;

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %b expected %b", tag, e, obs, exp);
    end
  endtask

  // An output follows its target only once the target has held the opposite
  // value for a full delay's worth of consecutive ticks.
  task automatic model_edge();
    logic trise, setup_bad, tq, tnq, both_low;
    if (!rst_n) begin
      m_s = 0; m_q = 0; m_nq = 1; m_viol = 0;
      m_t_prev = t; m_d_prev = d; m_last_chg = e;
      m_tq_run = 0; m_tnq_run = 0;
      return;
    end
    trise     = t && !m_t_prev;
    setup_bad = (d != m_d_prev) || ((e - m_last_chg - 1) < TSU);
    both_low  = !ps_n && !pc_n;
    tq        = m_s || both_low;
    tnq       = !m_s || both_low;

    m_tq_run  = (m_tq_run > 0 && tq == m_tq_last) ? m_tq_run + 1 : 1;
    m_tnq_run = (m_tnq_run > 0 && tnq == m_tnq_last) ? m_tnq_run + 1 : 1;
    m_tq_last = tq;
    m_tnq_last = tnq;
    if (tq != m_q && m_tq_run >= (tq ? TPLH : TPHL)) m_q = tq;
    if (tnq != m_nq && m_tnq_run >= (tnq ? TPLH : TPHL)) m_nq = tnq;

    if (trise && ps_n && pc_n && setup_bad) m_viol = 1;
    else if (vclr) m_viol = 0;

    if (!ps_n && pc_n) m_s = 1;
    else if (!pc_n && ps_n) m_s = 0;
    else if (ps_n && pc_n && trise) m_s = d;

    if (d != m_d_prev) m_last_chg = e;
    m_d_prev = d;
    m_t_prev = t;
  endtask

  task automatic step(input logic rr, input logic tt, input logic dd, input logic ps,
                      input logic pc, input logic vc);
    @(negedge clk);
    rst_n = rr; t = tt; d = dd; ps_n = ps; pc_n = pc; vclr = vc;
    @(posedge clk);
    e++;
    model_edge();
    #1;
    check_eq("q_model", q, m_q);
    check_eq("qn_model", q_n, m_nq);
    check_eq("viol_model", viol, m_viol);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step(rst_n, t, d, ps_n, pc_n, 1'b0);
  endtask

  initial begin
    rst_n = 0; t = 1; d = 1; ps_n = 1; pc_n = 1; vclr = 0;

    // Reset with T high, then release: no capture
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 1, 0);
    check_eq("rst_q", q, 1'b0);
    check_eq("rst_qn", q_n, 1'b1);
    check_eq("rst_viol", viol, 1'b0);
    for (int i = 0; i < 400; i++) step(1, 1, 1, 1, 1, 0);
    check_eq("rel_q", q, 1'b0);
    check_eq("rel_qn", q_n, 1'b1);

    // Normal capture of D=1
    step(1, 0, 1, 1, 1, 0);
    hold(50);
    step(1, 1, 1, 1, 1, 0);
    check_eq("cap_viol", viol, 1'b0);
    for (int k = 1; k <= 300; k++) begin
      step(1, 1, 1, 1, 1, 0);
      if (k == 27)  check_eq("cap_qn_27", q_n, 1'b1);
      if (k == 28)  check_eq("cap_qn_28", q_n, 1'b0);
      if (k == 279) check_eq("cap_q_279", q, 1'b0);
      if (k == 280) check_eq("cap_q_280", q, 1'b1);
    end
    check_eq("cap_viol_end", viol, 1'b0);

    // Setup violation: D changes 5 ticks before T rises
    step(1, 0, 1, 1, 1, 0);
    hold(3);
    step(1, 0, 0, 1, 1, 0);
    hold(4);
    step(1, 1, 0, 1, 1, 0);
    check_eq("viol_set", viol, 1'b1);
    hold(300);
    check_eq("viol_cap_q", q, 1'b0);
    check_eq("viol_cap_qn", q_n, 1'b1);
    step(1, 1, 0, 1, 1, 1);
    check_eq("viol_clr", viol, 1'b0);
    step(1, 0, 0, 1, 1, 0);
    step(1, 1, 1, 1, 1, 1);
    check_eq("viol_wins_clr", viol, 1'b1);
    hold(300);
    step(1, 1, 1, 1, 1, 1);
    check_eq("viol_clr2", viol, 1'b0);
    check_eq("viol_q_one", q, 1'b1);

    // Short clear pulses (re-armed by a fresh capture) are swallowed, twice over
    for (int r = 0; r < 2; r++) begin
      step(1, 0, 1, 1, 0, 0);
      hold(19);
      step(1, 1, 1, 1, 1, 0);
      step(1, 0, 1, 1, 1, 0);
      hold(30);
      check_eq("pulse_q", q, 1'b1);
      check_eq("pulse_qn", q_n, 1'b0);
    end
    check_eq("pulse_viol", viol, 1'b0);

    // Long clear
    step(1, 0, 1, 1, 0, 0);
    for (int k = 1; k <= 300; k++) begin
      step(1, 0, 1, 1, 0, 0);
      if (k == 27)  check_eq("clr_q_27", q, 1'b1);
      if (k == 28)  check_eq("clr_q_28", q, 1'b0);
      if (k == 279) check_eq("clr_qn_279", q_n, 1'b0);
      if (k == 280) check_eq("clr_qn_280", q_n, 1'b1);
    end
    step(1, 0, 1, 1, 1, 0);
    hold(20);

    // Preset and clear together drive both outputs high; S stays 0
    step(1, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 300; k++) begin
      step(1, 0, 1, 0, 0, 0);
      if (k == 150) check_eq("both_qn_mid", q_n, 1'b1);
      if (k == 278) check_eq("both_q_278", q, 1'b0);
      if (k == 280) check_eq("both_q_280", q, 1'b1);
    end
    check_eq("both_qn_end", q_n, 1'b1);
    step(1, 0, 1, 1, 1, 0);
    for (int k = 1; k <= 40; k++) begin
      step(1, 0, 1, 1, 1, 0);
      if (k == 26) check_eq("both_rel_q_26", q, 1'b1);
      if (k == 30) check_eq("both_rel_q_30", q, 1'b0);
    end
    check_eq("both_rel_qn", q_n, 1'b1);

    // Reset in the middle of Q rising
    step(1, 1, 1, 1, 1, 0);
    hold(100);
    step(0, 1, 1, 1, 1, 0);
    check_eq("midrst_q", q, 1'b0);
    check_eq("midrst_qn", q_n, 1'b1);
    check_eq("midrst_viol", viol, 1'b0);
    for (int i = 0; i < 400; i++) step(1, 1, 1, 1, 1, 0);
    check_eq("midrst_rel_q", q, 1'b0);
    check_eq("midrst_rel_qn", q_n, 1'b1);

    // Random stimulus: fast-toggling phase, then a slow phase that lets rises complete
    for (int ph = 0; ph < 2; ph++) begin
      int tdiv, ddiv;
      tdiv = (ph == 0) ? 8 : 350;
      ddiv = (ph == 0) ? 25 : 300;
      for (int i = 0; i < 3000; i++) begin
        logic nr, nt, nd, nps, npc, nv;
        nr  = ($urandom_range(0, 499) != 0);
        nt  = ($urandom_range(0, tdiv - 1) == 0) ? ~t : t;
        nd  = ($urandom_range(0, ddiv - 1) == 0) ? ~d : d;
        nps = ps_n ? ($urandom_range(0, 399) != 0) : ($urandom_range(0, 39) == 0);
        npc = pc_n ? ($urandom_range(0, 399) != 0) : ($urandom_range(0, 39) == 0);
        nv  = ($urandom_range(0, 39) == 0);
        step(nr, nt, nd, nps, npc, nv);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
